// File: rtl/note_spawner_top.sv
// Top-of-column note source: on each beat it pseudo-randomly launches at most one note into
// the first row of one lane. It also provides run/stop/drain control and a per-run note count.
module note_spawner_top #(
   parameter int          LANES   = 4,
   parameter int          ROWS    = 8,
   parameter logic [9:0]  SEED    = 10'h2A5,
   parameter int          GAP_MIN = 1
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             is10,
   input  logic             start,
   input  logic             stop,
   input  logic [1:0]       density,
   output logic [LANES-1:0] spawnLights,
   output logic             active,
   output logic [7:0]       noteCount
);

   localparam int               LW         = $clog2(LANES);
   localparam int               DCW        = (ROWS > 2) ? $clog2(ROWS) : 1;
   localparam logic [9:0]       SEED_EFF   = (SEED == 10'h000) ? 10'h001 : SEED;
   localparam logic [3:0]       GAP_INIT   = 4'(GAP_MIN);
   localparam logic [DCW-1:0]   DRAIN_LAST = DCW'(ROWS - 1);
   localparam logic [LANES-1:0] LANE0      = {{(LANES-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

   // Maximal-length 10-bit Fibonacci LFSR with taps at bits 9 and 6
   function automatic logic [9:0] lfsr_next(input logic [9:0] v);
      return {v[8:0], v[9] ^ v[6]};
   endfunction

   state_t           state_r, state_nx_s;
   logic [9:0]       lfsr_r, lfsr_nx_s, lfsr_step_s;
   logic [3:0]       gap_r, gap_nx_s, threshold_s;
   logic [DCW-1:0]   drain_r, drain_nx_s;
   logic [LANES-1:0] spawn_r, spawn_nx_s;
   logic [7:0]       count_r, count_nx_s;
   logic             active_r, active_nx_s;
   logic             spawn_s;
   logic [LW-1:0]    lane_s;

   assign lfsr_step_s = lfsr_next(lfsr_r);
   assign threshold_s = {density, 2'b00};
   assign spawn_s     = (gap_r >= GAP_INIT) && (lfsr_step_s[3:0] < threshold_s);
   assign lane_s      = lfsr_step_s[4 +: LW];

   // Next-state and next-output decode for the IDLE/RUN/DRAIN controller
   always_comb begin
      state_nx_s = state_r;
      lfsr_nx_s  = lfsr_r;
      gap_nx_s   = gap_r;
      drain_nx_s = drain_r;
      spawn_nx_s = spawn_r;
      count_nx_s = count_r;
      case (state_r)
         IDLE: begin
            if (start && !stop) begin
               state_nx_s = RUN;
               count_nx_s = 8'd0;
               gap_nx_s   = GAP_INIT;
            end else begin
               state_nx_s = IDLE;
            end
         end
         RUN: begin
            if (stop) begin
               state_nx_s = DRAIN;
               spawn_nx_s = {LANES{1'b0}};
               drain_nx_s = {DCW{1'b0}};
            end else if (is10) begin
               // The decision uses the freshly stepped value, not the stored one
               lfsr_nx_s = lfsr_step_s;
               if (spawn_s) begin
                  spawn_nx_s = LANE0 << lane_s;
                  gap_nx_s   = 4'd0;
                  count_nx_s = (count_r == 8'hFF) ? 8'hFF : count_r + 8'd1;
               end else begin
                  spawn_nx_s = {LANES{1'b0}};
                  gap_nx_s   = (gap_r == 4'hF) ? 4'hF : gap_r + 4'd1;
               end
            end else begin
               state_nx_s = RUN;
            end
         end
         DRAIN: begin
            if (is10) begin
               if (drain_r == DRAIN_LAST) begin
                  state_nx_s = IDLE;
                  drain_nx_s = {DCW{1'b0}};
               end else begin
                  drain_nx_s = drain_r + DCW'(1);
               end
            end else begin
               state_nx_s = DRAIN;
            end
         end
         default: begin
            state_nx_s = IDLE;
            spawn_nx_s = {LANES{1'b0}};
         end
      endcase
      active_nx_s = (state_nx_s != IDLE);
   end

   // State, LFSR, and registered outputs
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_r  <= IDLE;
         lfsr_r   <= SEED_EFF;
         gap_r    <= GAP_INIT;
         drain_r  <= {DCW{1'b0}};
         spawn_r  <= {LANES{1'b0}};
         count_r  <= 8'd0;
         active_r <= 1'b0;
      end else begin
         state_r  <= state_nx_s;
         lfsr_r   <= lfsr_nx_s;
         gap_r    <= gap_nx_s;
         drain_r  <= drain_nx_s;
         spawn_r  <= spawn_nx_s;
         count_r  <= count_nx_s;
         active_r <= active_nx_s;
      end
   end

   assign spawnLights = spawn_r;
   assign active      = active_r;
   assign noteCount   = count_r;

endmodule

// File: doc/note_spawner_top.md
Name: note_spawner_top

Overview:
- Top-of-column note source for the DDR lane grid. It is the injecting end of the row-light chain, where the bottom-row stage is the consuming end.
- On every is10 beat it pseudo-randomly decides whether to launch a note and in which lane. It drives a one-hot spawnLights vector into the preLight inputs of the first row of each lane.
- Provides run/stop control, a drain phase so falling notes clear the grid, and a spawned-note counter for the scorer.

Parameters:
- LANES, 4, number of arrow lanes; power of two, 2..8.
- ROWS, 8, rows per lane; sets the drain length in beats.
- SEED, 10'h2A5, LFSR reload value on Reset; 0 is illegal and is forced to 10'h001.
- GAP_MIN, 1, minimum non-spawn beats between two spawns; 0 allows back-to-back spawns.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- is10  in  1  beat enable, 1-cycle pulse; all beat-state advances only on cycles where is10=1.
- start  in  1  level, sampled each Clock; begins a run.
- stop  in  1  level, sampled each Clock; ends a run.
- density  in  2  spawn probability select.
- spawnLights  out  LANES  one-hot or zero; connects to first-row preLight per lane.
- active  out  1  high in RUN and DRAIN.
- noteCount  out  8  notes spawned this run; saturates at 255.

Behaviour:
- Reset (async) values: state=IDLE, spawnLights=0, active=0, noteCount=0, lfsr=SEED (or 1 if SEED=0), gap=GAP_MIN, drainCnt=0.
- FSM states: IDLE, RUN, DRAIN. Transitions are taken on any Clock edge, not gated by is10.
- IDLE: start=1 and stop=0 → RUN. On entry, noteCount=0 and gap=GAP_MIN. stop has priority if both are high. The lfsr is not reloaded, so successive runs differ.
- RUN: stop=1 → DRAIN, with spawnLights cleared on the same edge and drainCnt=0. start is ignored.
- DRAIN: no spawns. drainCnt increments on each is10. When drainCnt reaches ROWS-1 on an is10 edge → IDLE. start and stop are ignored.
- LFSR: 10-bit Fibonacci, next = {lfsr[8:0], lfsr[9]^lfsr[6]}. It steps only on is10 edges while in RUN.
- Spawn decision: made on each is10 edge in RUN, using the post-step value L.
  - threshold = {0,4,8,12}[density].
  - eligible = (gap >= GAP_MIN).
  - spawn = eligible && (L[3:0] < threshold).
  - lane = L[4+log2(LANES)-1 : 4].
- Registered outputs on each is10 edge in RUN:
  - spawnLights = spawn ? (1<<lane) : 0.
  - gap = spawn ? 0 : min(gap+1, 15).
  - noteCount = spawn ? sat255(noteCount+1) : noteCount.
- spawnLights timing: it holds its value between beats, so each note is presented for exactly one beat period. Latency is the is10 edge to spawnLights valid at the next cycle (registered).
- Invariant: spawnLights is never multi-hot.
- The RUN-entry edge does not count as a beat, even if is10 is high on that edge. The first decision is made on the first is10 edge with state already RUN.
- density changes take effect at the next beat. noteCount holds through DRAIN and IDLE until the next start.
- Reset mid-run aborts immediately to the reset values.

Test Plan:
- Reset, SEED=2A5, density=3, start, then 3 beats → lfsr sequence 14B, 297, 12F; spawnLights sequence 0001 (lane 0), 0000 (gap block), 0000 (nibble F ≥ 12); noteCount=1.
- density=0, RUN for 50 beats → spawnLights always 0, noteCount=0, lfsr still advances 50 steps.
- GAP_MIN=0, density=3, force lfsr low nibble < 12 on consecutive beats → spawns on back-to-back beats; with GAP_MIN=1 the second spawn is suppressed.
- stop during RUN with a note showing → spawnLights=0 on the next edge, active stays high for exactly ROWS=8 beats, then IDLE with active=0 and noteCount unchanged.
- start and stop together in IDLE → stays IDLE. start pulse in DRAIN → ignored.
- Async Reset mid-RUN between Clock edges → outputs zero immediately, lfsr=2A5. Also check noteCount stops at 255 after 300 forced spawns.
